// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory slave with a fixed response latency.
//
// A request is accepted in IDLE when req_valid_i && req_ready_o. The request
// fields are captured, the FSM waits LATENCY cycles in WAIT, then the store is
// committed (or the load data is captured) on the edge entering RESP. The
// response is held, registered, until resp_ready_i. Misaligned or out-of-range
// requests return resp_err_o=1 and rdata=0 and never touch memory.
//
// Ports
//   clk_i, rst_i        clock, async active-low reset
//   req_valid_i/ready_o request handshake
//   req_we_i            1 = store, 0 = load
//   req_addr_i          byte address (word aligned, < 4*DEPTH)
//   req_wdata_i/be_i    store data and byte enables
//   resp_valid_o/ready_i response handshake
//   resp_rdata_o        load data (0 for stores and errors)
//   resp_err_o          misaligned / out-of-range flag
//
// Storage is split into four byte-lane banks so byte enables map directly onto
// per-bank write enables. Memory is not reset.

module mem_responder_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] bank_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) bank_q[idx_i] <= wdata_i;
  end

  // Combinational read: sampled by the top on the edge entering RESP.
  assign rdata_o = bank_q[idx_i];
endmodule

module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        vld_q;
  logic        err_q;
  logic [31:0] rdata_q;
  req_t        req_q;

  req_t                          req_in;
  req_t                          cur;
  logic                          accept;
  logic                          go_resp;
  logic                          cur_err;
  logic [AW-1:0]                 cur_idx;
  logic [NUM_LANES-1:0][7:0]     rd_lane;
  logic [31:0]                   rdata_d;
  logic                          err_d;

  assign req_in = {req_we_i, req_addr_i, req_wdata_i, req_be_i};
  assign accept = (state_q == IDLE) && ready_q && req_valid_i;

  // With zero latency the transaction resolves on the accept edge, so the live
  // inputs are the transaction; otherwise the captured copy is used.
  assign cur = (state_q == IDLE) ? req_in : req_q;

  assign go_resp = (LATENCY == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));

  assign cur_err = (cur.addr[1:0] != 2'b00) || (|cur.addr[31:AW+2]);
  assign cur_idx = cur.addr[AW+1:2];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_responder_lane #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clk_i   (clk_i),
      .we_i    (go_resp & cur.we & ~cur_err & cur.be[i]),
      .idx_i   (cur_idx),
      .wdata_i (cur.wdata[8*i +: 8]),
      .rdata_o (rd_lane[i])
    );
  end

  assign rdata_d = (cur.we || cur_err) ? 32'd0 : rd_lane;
  assign err_d   = cur_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q   <= req_in;
            ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q <= RESP;
              vld_q   <= 1'b1;
              rdata_q <= rdata_d;
              err_q   <= err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            // Also the path that raises ready on the first cycle after reset.
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            vld_q   <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = vld_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
endmodule
